instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0, address of the first emitted word.
REQ-003 SHALL have one clock and one reset; the reset SHALL be asynchronous and active-high.
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  field bundle valid.
REQ-007 in_ready  output  1  encoder can accept a bundle.
REQ-008 in_type  input  3  0=R, 1=I, 2=IL, 3=S, 4=B, 5=J, 6=JR, 7=illegal.
REQ-009 in_rd / in_rs1 / in_rs2  input  5 each  register addresses.
REQ-010 in_funct3  input  3; in_funct7  input  7  function fields.
REQ-011 in_imm  input  20  immediate; [11:0] for I/IL/S/B/JR, [19:0] for J.
REQ-012 out_valid  output  1  encoded word available.
REQ-013 out_ready  input  1  consumer (instruction-memory writer) accepts word.
REQ-014 out_instr  output  32  encoded instruction word.
REQ-015 out_addr  output  32  byte address of out_instr.
REQ-016 err_o  output  1  one-cycle pulse on an illegal bundle.
REQ-017 err_cnt  output  8  count of illegal bundles.

Function
REQ-018 Accepting a bundle SHALL require in_valid && in_ready at a rising edge.
REQ-019 in_ready SHALL equal !full and SHALL NOT depend on out_ready or in_valid.
REQ-020 Opcodes: R 0110011, I 0010011, IL 0000011, S 0100011, B 1100011, J 1101111, JR 1100111.
REQ-021 R: {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-022 I, IL, JR: {imm[11:0], rs1, funct3, rd, opcode}.
REQ-023 S, B: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}, matching the codebase's B immediate format (no bit scrambling).
REQ-024 J: {imm[19:0], rd, opcode}.
REQ-025 Input fields unused by the type SHALL be ignored.
REQ-026 Encoding SHALL be combinational and written into the FIFO on the accept edge; out_valid SHALL assert the cycle after an accept into an empty FIFO (latency 1).
REQ-027 Words SHALL leave in acceptance order; a pop occurs when out_valid && out_ready.
REQ-028 out_instr and out_addr SHALL be held stable while out_valid && !out_ready.
REQ-029 out_addr SHALL advance by 4 on each pop and wrap modulo 2^32.
REQ-030 Full: in_ready=0 even if a pop occurs that cycle; the next cycle shows in_ready=1.
REQ-031 Simultaneous push and pop with 0<occupancy<DEPTH SHALL keep occupancy unchanged.
REQ-032 Empty: out_valid=0; out_instr value is don't-care.
REQ-033 An illegal type (7) SHALL be accepted (handshake completes) but not written; err_o SHALL pulse one cycle after the accept edge; err_cnt SHALL increment and saturate at 255.
REQ-034 Illegal bundles SHALL NOT advance out_addr.

Reset
REQ-035 On rst: FIFO empty, out_valid=0, in_ready=1, out_addr=BASE_ADDR, err_o=0, err_cnt=0, out_instr=0.
REQ-036 Reset mid-operation SHALL discard all buffered words immediately, regardless of clock.

Verification
REQ-037 R rd=3 rs1=1 rs2=2 f3=0 f7=0, out_ready=1 -> out_instr=0x002081B3, out_addr=0x0, one cycle after accept.
REQ-038 I rd=5 rs1=0 f3=0 imm=0x7FF, then S rs1=2 rs2=3 f3=2 imm=0x008 -> 0x7FF00293 @0x0, 0x00312423 @0x4.
REQ-039 J rd=1 imm=0x00010 -> out_instr=0x000100EF.
REQ-040 out_ready=0, 5 back-to-back bundles -> in_ready low after the 4th accept; out_ready=1 -> 4 words in order at 0x0, 0x4, 0x8, 0xC; the 5th is then accepted at 0x10.
REQ-041 type=7 bundle -> err_o pulses 1 cycle, err_cnt=1, out_valid stays 0, out_addr unchanged; 256 illegals -> err_cnt=255.
REQ-042 rst asserted with 2 entries buffered -> out_valid=0, in_ready=1, out_addr=BASE_ADDR, err_cnt=0 before the next clock edge.

Source files
------------

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into 32-bit words and queues them with byte addresses.
// Latency 1 from accept to out_valid; in_ready drops only when the FIFO is full.
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_type,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [19:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_o,
    output logic [7:0]  err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        T_R   = 3'd0,
        T_I   = 3'd1,
        T_IL  = 3'd2,
        T_S   = 3'd3,
        T_B   = 3'd4,
        T_J   = 3'd5,
        T_JR  = 3'd6,
        T_ILL = 3'd7
    } instr_type_e;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_addr;
    logic          r_err;
    logic [7:0]    r_err_cnt;

    instr_type_e   w_type;
    logic [31:0]   w_enc;
    logic          w_full;
    logic          w_empty;
    logic          w_accept;
    logic          w_illegal;
    logic          w_push;
    logic          w_pop;

    assign w_type    = instr_type_e'(in_type);
    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_accept  = in_valid && !w_full;
    assign w_illegal = (w_type == T_ILL);
    assign w_push    = w_accept && !w_illegal;
    assign w_pop     = !w_empty && out_ready;

    // B uses the same immediate split as S; no RISC-V bit scrambling.
    always_comb begin
        w_enc = 32'h0;
        case (w_type)
            T_R:  w_enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            T_I:  w_enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
            T_IL: w_enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
            T_JR: w_enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b1100111};
            T_S:  w_enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
            T_B:  w_enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b1100011};
            T_J:  w_enc = {in_imm, in_rd, 7'b1101111};
            default: w_enc = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_enc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_addr   <= BASE_ADDR;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_addr   <= r_addr + 32'd4;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err     <= 1'b0;
            r_err_cnt <= 8'h0;
        end else begin
            r_err <= w_accept && w_illegal;
            if (w_accept && w_illegal && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    // Empty FIFO drives zero so the reset value of out_instr is defined.
    assign out_instr = w_empty ? 32'h0 : r_mem[r_rd_ptr];
    assign out_valid = !w_empty;
    assign in_ready  = !w_full;
    assign out_addr  = r_addr;
    assign err_o     = r_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: driver pushes model words, negedge monitor pops and compares.
module tb_instr_encoder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_type = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [19:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err_o;
    logic [7:0]  err_cnt;

    int          nassert = 0;
    int          nfail = 0;
    logic [31:0] q[$];
    logic [31:0] exp_addr = BASE;
    bit          exp_err = 1'b0;
    int          exp_cnt = 0;
    bit          acc;

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err_o(err_o), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nassert++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Field placement by shift-and-add from the format table.
    function automatic logic [31:0] model(input int ty, input int rd, input int rs1, input int rs2,
                                          input int f3, input int f7, input int imm);
        int unsigned opc [7] = '{51, 19, 3, 35, 99, 111, 103};
        int unsigned w;
        int unsigned i12, i20;
        i12 = int'(imm) % 4096;
        i20 = int'(imm) % 1048576;
        w = opc[ty] + (int'(rs1) << 15) + (int'(f3) << 12);
        case (ty)
            0:       w = w + (rd << 7) + (rs2 << 20) + (f7 << 25);
            1, 2, 6: w = w + (rd << 7) + (i12 << 20);
            3, 4:    w = w + ((i12 % 32) << 7) + (rs2 << 20) + ((i12 / 32) << 25);
            default: w = opc[ty] + (rd << 7) + (i20 << 12);
        endcase
        return w;
    endfunction

    task automatic cycle(input bit v, input int ty, input int rd, input int rs1, input int rs2,
                         input int f3, input int f7, input int imm, input bit ordy,
                         input bit use_x, input logic [31:0] xw, output bit accepted);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_type   = 3'(ty);
        in_rd     = 5'(rd);
        in_rs1    = 5'(rs1);
        in_rs2    = 5'(rs2);
        in_funct3 = 3'(f3);
        in_funct7 = 7'(f7);
        in_imm    = 20'(imm);
        out_ready = ordy;
        #1;
        check("in_ready", {31'b0, in_ready}, {31'b0, q.size() < DEPTH});
        check("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
        check("err_o", {31'b0, err_o}, {31'b0, exp_err});
        check("err_cnt", {24'b0, err_cnt}, 32'(exp_cnt));
        exp_err  = 1'b0;
        accepted = v && (q.size() < DEPTH);
        if (accepted) begin
            if (ty == 7) begin
                exp_err = 1'b1;
                if (exp_cnt < 255) exp_cnt++;
            end else begin
                q.push_back(use_x ? xw : model(ty, rd, rs1, rs2, f3, f7, imm));
            end
        end
    endtask

    task automatic idle(input bit ordy, input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0, 0, 0, 0, 0, ordy, 1'b0, 32'h0, a);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_in_ready", {31'b0, in_ready}, 32'h1);
        check("rst_out_addr", out_addr, BASE);
        check("rst_err_cnt", {24'b0, err_cnt}, 32'h0);
        check("rst_err_o", {31'b0, err_o}, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        q.delete();
        exp_addr = BASE;
        exp_err  = 1'b0;
        exp_cnt  = 0;
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_word", out_instr, 32'hXXXXXXXX);
            end else begin
                check("out_instr", out_instr, q[0]);
                check("out_addr", out_addr, exp_addr);
                if (out_ready) begin
                    void'(q.pop_front());
                    exp_addr = exp_addr + 32'd4;
                end
            end
        end
    end

    initial begin
        do_reset();

        cycle(1'b1, 0, 3, 1, 2, 0, 0, 0, 1'b1, 1'b1, 32'h002081B3, acc);
        idle(1'b1, 2);

        do_reset();
        cycle(1'b1, 1, 5, 0, 0, 0, 0, 'h7FF, 1'b1, 1'b1, 32'h7FF00293, acc);
        cycle(1'b1, 3, 0, 2, 3, 2, 0, 'h008, 1'b1, 1'b1, 32'h00312423, acc);
        idle(1'b1, 3);

        do_reset();
        cycle(1'b1, 5, 1, 0, 0, 0, 0, 'h00010, 1'b1, 1'b1, 32'h000100EF, acc);
        idle(1'b1, 2);

        do_reset();
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 0, i + 1, i, i + 2, 0, 0, 0, 1'b0, 1'b0, 32'h0, acc);
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++)
            cycle(1'b1, 0, 5, 4, 6, 0, 0, 0, 1'b1, 1'b0, 32'h0, acc);
        check("fifth_accepted", {31'b0, acc}, 32'h1);
        idle(1'b1, 8);
        check("fifth_addr", exp_addr, 32'h14);

        do_reset();
        cycle(1'b1, 7, 1, 1, 1, 0, 0, 0, 1'b1, 1'b0, 32'h0, acc);
        idle(1'b1, 2);
        for (int i = 0; i < 260; i++)
            cycle(1'b1, 7, i % 32, 0, 0, 0, 0, i, 1'b1, 1'b0, 32'h0, acc);
        idle(1'b1, 2);
        check("err_cnt_sat", {24'b0, err_cnt}, 32'd255);

        do_reset();
        cycle(1'b1, 1, 2, 3, 0, 1, 0, 'h123, 1'b0, 1'b0, 32'h0, acc);
        cycle(1'b1, 4, 0, 7, 9, 5, 0, 'hABC, 1'b0, 1'b0, 32'h0, acc);
        cycle(1'b1, 7, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 32'h0, acc);
        idle(1'b0, 1);
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 9) < 7, int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 127)), int'($urandom & 32'hFFFFF),
                  $urandom_range(0, 9) < 6, 1'b0, 32'h0, acc);
        end
        idle(1'b1, DEPTH + 4);
        check("drained", 32'(q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
